// File: rtl/mul_rr_sched.sv
// Round-robin scheduler sharing one signed Q1.7 multiplier between N_REQ
// requesters. Two-stage pipeline (operand register, response register)
// with valid/ready handshakes on both sides and a fixed 2-cycle latency.

// Combinational signed 8x8 multiplier with Q1.7 truncation and wrap flag.
module multiplier_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] out_16,
  output logic [7:0]  out_8,
  output logic        ovf
);
  logic signed [15:0] prod;

  assign prod   = $signed(a) * $signed(b);
  assign out_16 = prod;
  // Q2.14 -> Q1.7 by dropping bit 14 and the low 7 bits (truncate toward -inf)
  assign out_8  = {prod[15], prod[13:7]};
  // Only -1.0 * -1.0 lands here; the Q1.7 result wraps to 0
  assign ovf    = prod[15] ^ prod[14];
endmodule

module mul_rr_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 I_CLK,
  input  logic                 I_RST,
  input  logic [N_REQ-1:0]     I_REQ_VALID,
  input  logic [8*N_REQ-1:0]   I_REQ_IN1,
  input  logic [8*N_REQ-1:0]   I_REQ_IN2,
  output logic [N_REQ-1:0]     O_REQ_READY,
  output logic                 O_RSP_VALID,
  input  logic                 I_RSP_READY,
  output logic [ID_W-1:0]      O_RSP_ID,
  output logic [15:0]          O_RSP_OUT_16,
  output logic [7:0]           O_RSP_OUT_8,
  output logic                 O_RSP_OVF,
  output logic                 O_BUSY
);

  logic [7:0]      in1_arr [N_REQ];
  logic [7:0]      in2_arr [N_REQ];

  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] ptr_next;

  logic [7:0]      s1_in1_reg;
  logic [7:0]      s1_in2_reg;
  logic [ID_W-1:0] s1_id_reg;
  logic            s1_v_reg;

  logic [15:0]     s2_out16_reg;
  logic [7:0]      s2_out8_reg;
  logic            s2_ovf_reg;
  logic [ID_W-1:0] s2_id_reg;
  logic            s2_v_reg;

  logic            s1_en;
  logic            s2_en;
  logic            accept;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic [ID_W:0]   cand;

  logic [15:0]     mul_out16;
  logic [7:0]      mul_out8;
  logic            mul_ovf;

  // Unpack operand buses and build the one-hot ready vector per requester
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign in1_arr[gi]     = I_REQ_IN1[8*gi +: 8];
      assign in2_arr[gi]     = I_REQ_IN2[8*gi +: 8];
      assign O_REQ_READY[gi] = accept && (grant_id == ID_W'(gi));
    end
  endgenerate

  // Each stage advances when its downstream slot is free or being emptied
  assign s2_en  = !s2_v_reg || I_RSP_READY;
  assign s1_en  = !s1_v_reg || s2_en;
  // Reset gates acceptance so ready stays low while reset is held
  assign accept = s1_en && grant_valid && !I_RST;

  // Circular priority search over valids, starting at the pointer
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_reg} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!grant_valid && I_REQ_VALID[cand[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
  end

  // Next pointer: one past the winner, wrapping at N_REQ
  always_comb begin
    ptr_next = ptr_reg;
    if (accept) begin
      if (grant_id == ID_W'(N_REQ - 1)) ptr_next = '0;
      else                              ptr_next = grant_id + ID_W'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge I_CLK) begin
    if (I_RST) ptr_reg <= '0;
    else       ptr_reg <= ptr_next;
  end

  // S1 operand register: capture the granted pair, or empty when passed on
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      s1_in1_reg <= '0;
      s1_in2_reg <= '0;
      s1_id_reg  <= '0;
      s1_v_reg   <= 1'b0;
    end else if (accept) begin
      s1_in1_reg <= in1_arr[grant_id];
      s1_in2_reg <= in2_arr[grant_id];
      s1_id_reg  <= grant_id;
      s1_v_reg   <= 1'b1;
    end else if (s1_en) begin
      s1_v_reg   <= 1'b0;
    end
  end

  multiplier_8 u_mul (
    .a      (s1_in1_reg),
    .b      (s1_in2_reg),
    .out_16 (mul_out16),
    .out_8  (mul_out8),
    .ovf    (mul_ovf)
  );

  // S2 response register: holds steady while the consumer stalls
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      s2_out16_reg <= '0;
      s2_out8_reg  <= '0;
      s2_ovf_reg   <= 1'b0;
      s2_id_reg    <= '0;
      s2_v_reg     <= 1'b0;
    end else if (s2_en) begin
      s2_out16_reg <= mul_out16;
      s2_out8_reg  <= mul_out8;
      s2_ovf_reg   <= mul_ovf;
      s2_id_reg    <= s1_id_reg;
      s2_v_reg     <= s1_v_reg;
    end
  end

  assign O_RSP_VALID  = s2_v_reg;
  assign O_RSP_ID     = s2_id_reg;
  assign O_RSP_OUT_16 = s2_out16_reg;
  assign O_RSP_OUT_8  = s2_out8_reg;
  assign O_RSP_OVF    = s2_ovf_reg;
  assign O_BUSY       = s1_v_reg || s2_v_reg;

endmodule

// File: tb/tb_mul_rr_sched.sv
// Self-checking bench for mul_rr_sched: per-requester operand queues drive
// the request side, a round-robin/occupancy model predicts ready, and a
// scoreboard of expected products is popped as responses are consumed.
module tb_mul_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_out16;
  logic [7:0]  rsp_out8;
  logic        rsp_ovf;
  logic        busy;

  always #5 clk = ~clk;

  mul_rr_sched #(.N_REQ(4), .ID_W(2)) dut (
    .I_CLK        (clk),
    .I_RST        (rst),
    .I_REQ_VALID  (req_valid),
    .I_REQ_IN1    (in1),
    .I_REQ_IN2    (in2),
    .O_REQ_READY  (req_ready),
    .O_RSP_VALID  (rsp_valid),
    .I_RSP_READY  (rsp_ready),
    .O_RSP_ID     (rsp_id),
    .O_RSP_OUT_16 (rsp_out16),
    .O_RSP_OUT_8  (rsp_out8),
    .O_RSP_OVF    (rsp_ovf),
    .O_BUSY       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Operand entries: {a[40:33], b[32:25], exp16[24:9], exp8[8:1], expovf[0]}
  logic [40:0] ops [4][64];
  int          rd [4];
  int          wr [4];
  logic [3:0]  en_mask     = 4'hF;
  bit          force_valid = 1'b0;

  // Reference model state
  int          m_ptr   = 0;
  bit          m_s1_v  = 1'b0;
  bit          m_s2_v  = 1'b0;
  bit          after_rst = 1'b1;
  logic [26:0] exp_q[$];
  int          grant_log[$];
  int          n_acc = 0;

  bit          stalled_prev = 1'b0;
  logic [1:0]  hold_id;
  logic [15:0] hold_out16;
  logic [7:0]  hold_out8;
  logic        hold_ovf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] mk(input logic [7:0] a, input logic [7:0] b);
    int          p;
    logic [15:0] p16;
    p   = int'($signed(a)) * int'($signed(b));
    p16 = p[15:0];
    return {a, b, p16, p16[15], p16[13:7], p16[15] ^ p16[14]};
  endfunction

  function automatic logic [40:0] mkc(input logic [7:0] a, input logic [7:0] b,
                                      input logic [15:0] e16, input logic [7:0] e8,
                                      input logic eovf);
    return {a, b, e16, e8, eovf};
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < 4; i++) s += wr[i] - rd[i];
    return s;
  endfunction

  task automatic push(input int r, input logic [40:0] e);
    ops[r][wr[r]] = e;
    wr[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (rd[i] < wr[i]) begin
        in1[8*i +: 8] = ops[i][rd[i]][40:33];
        in2[8*i +: 8] = ops[i][rd[i]][32:25];
      end else begin
        in1[8*i +: 8] = 8'h00;
        in2[8*i +: 8] = 8'h00;
      end
      req_valid[i] = force_valid || (en_mask[i] && (rd[i] < wr[i]));
    end
  endtask

  // One clock: check at negedge, advance the model at posedge, re-drive
  task automatic tick();
    logic [3:0]  e_ready;
    logic [26:0] e;
    logic [40:0] op;
    int          g;
    bit          any;
    bit          s1en;
    bit          s2en;
    @(negedge clk);
    s2en = !m_s2_v || rsp_ready;
    s1en = !m_s1_v || s2en;
    any  = 1'b0;
    g    = 0;
    for (int k = 0; k < 4; k++) begin
      if (!any && req_valid[(m_ptr + k) % 4]) begin
        any = 1'b1;
        g   = (m_ptr + k) % 4;
      end
    end
    e_ready = (any && s1en && !rst) ? 4'(1 << g) : 4'b0000;
    check_val("req_ready", 32'(req_ready), 32'(e_ready));
    check_val("rsp_valid", 32'(rsp_valid), 32'(m_s2_v));
    check_val("busy", 32'(busy), 32'(m_s1_v || m_s2_v));
    if (after_rst) begin
      check_val("rst_id", 32'(rsp_id), 32'd0);
      check_val("rst_out16", 32'(rsp_out16), 32'd0);
      check_val("rst_out8", 32'(rsp_out8), 32'd0);
      check_val("rst_ovf", 32'(rsp_ovf), 32'd0);
    end
    if (rsp_valid && stalled_prev) begin
      check_val("hold_id", 32'(rsp_id), 32'(hold_id));
      check_val("hold_out16", 32'(rsp_out16), 32'(hold_out16));
      check_val("hold_out8", 32'(rsp_out8), 32'(hold_out8));
      check_val("hold_ovf", 32'(rsp_ovf), 32'(hold_ovf));
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("rsp id=%0d out16=%h out8=%h ovf=%0d", rsp_id, rsp_out16, rsp_out8, rsp_ovf);
        check_val("rsp_id", 32'(rsp_id), 32'(e[26:25]));
        check_val("rsp_out16", 32'(rsp_out16), 32'(e[24:9]));
        check_val("rsp_out8", 32'(rsp_out8), 32'(e[8:1]));
        check_val("rsp_ovf", 32'(rsp_ovf), 32'(e[0]));
      end
    end
    stalled_prev = rsp_valid && !rsp_ready;
    hold_id      = rsp_id;
    hold_out16   = rsp_out16;
    hold_out8    = rsp_out8;
    hold_ovf     = rsp_ovf;
    @(posedge clk);
    if (rst) begin
      m_ptr     = 0;
      m_s1_v    = 1'b0;
      m_s2_v    = 1'b0;
      after_rst = 1'b1;
      exp_q.delete();
      grant_log.delete();
    end else begin
      after_rst = 1'b0;
      if (s2en) m_s2_v = m_s1_v;
      if (any && s1en) begin
        op     = ops[g][rd[g]];
        rd[g]++;
        exp_q.push_back({2'(g), op[24:0]});
        grant_log.push_back(g);
        m_s1_v = 1'b1;
        m_ptr  = (g + 1) % 4;
        n_acc++;
      end else if (s1en) begin
        m_s1_v = 1'b0;
      end
    end
    #1;
    drive();
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    en_mask   = 4'hF;
    drive();
    for (int i = 0; i < 200; i++) begin
      if (pending() == 0 && !m_s1_v && !m_s2_v) break;
      tick();
    end
    check_val("drain_pending", 32'(pending()), 32'd0);
    check_val("drain_scoreboard", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    for (int i = 0; i < 4; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    rst         = 1'b1;
    rsp_ready   = 1'b1;
    force_valid = 1'b1;
    in1         = '0;
    in2         = '0;
    req_valid   = 4'hF;
    @(posedge clk);
    #1;

    // Reset with valids high, then round-robin across all four requesters
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 4; i++)
        push(i, mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))));
    drive();
    tick();
    tick();
    rst         = 1'b0;
    force_valid = 1'b0;
    drive();
    for (int n = 0; n < 8; n++) tick();
    check_val("rr_grants", 32'(grant_log.size()), 32'd8);
    for (int n = 0; n < 8 && n < grant_log.size(); n++)
      check_val("rr_order", 32'(grant_log[n]), 32'(n % 4));
    drain();

    // Single request from requester 1
    push(1, mkc(8'h40, 8'h40, 16'h1000, 8'h20, 1'b0));
    drive();
    drain();

    // Signed and overflow corners; 127 * -127 = -16129 = 0xC0FF
    push(2, mkc(8'hC0, 8'h40, 16'hF000, 8'hE0, 1'b0));
    push(3, mkc(8'h80, 8'h80, 16'h4000, 8'h00, 1'b1));
    push(0, mkc(8'h7F, 8'h81, 16'hC0FF, 8'h81, 1'b0));
    push(1, mkc(8'hFF, 8'hFF, 16'h0001, 8'h00, 1'b0));
    drive();
    drain();

    // Back-pressure: consumer stalled for 5 cycles under continuous demand
    for (int n = 0; n < 3; n++)
      for (int i = 0; i < 4; i++)
        push(i, mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))));
    rsp_ready = 1'b0;
    drive();
    acc0 = n_acc;
    for (int n = 0; n < 5; n++) tick();
    check_val("bp_accepts", 32'(n_acc - acc0), 32'd2);
    drain();

    // Random stall and request-withdrawal traffic
    for (int n = 0; n < 8; n++)
      for (int i = 0; i < 4; i++)
        push(i, mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))));
    for (int n = 0; n < 80; n++) begin
      en_mask   = 4'($urandom_range(0, 15));
      rsp_ready = 1'($urandom_range(0, 1));
      drive();
      tick();
    end
    drain();

    // Reset one cycle after an accept: product discarded, pointer back to 0
    push(2, mk(8'h11, 8'h22));
    drive();
    acc0 = n_acc;
    for (int n = 0; n < 10 && n_acc == acc0; n++) tick();
    check_val("mf_accepted", 32'(n_acc - acc0), 32'd1);
    rst = 1'b1;
    drive();
    tick();
    rst = 1'b0;
    drive();
    for (int n = 0; n < 4; n++) tick();
    check_val("mf_busy", 32'(busy), 32'd0);
    check_val("mf_rsp_valid", 32'(rsp_valid), 32'd0);
    push(1, mk(8'h05, 8'hF0));
    push(3, mk(8'h33, 8'h44));
    drive();
    tick();
    check_val("mf_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 99), 32'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
